// File: rtl/fifo_shift_fwft_pkg.sv
// Package shared by the shift-register FIFO slice.
// Holds the read-mode constants, the per-stage mux select type and the
// helper that derives the occupancy counter width from the depth.
package fifo_pkg;

  // Read-mode selectors for the SHOW_AHEAD parameter.
  localparam bit RD_SHOW_AHEAD = 1'b1;
  localparam bit RD_REGISTERED = 1'b0;

  // Per-entry register update choice.
  typedef enum logic [1:0] {
    STG_HOLD  = 2'd0,
    STG_SHIFT = 2'd1,
    STG_LOAD  = 2'd2
  } stage_sel_e;

  // Width needed to hold the values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    if (depth < 1) begin
      return 1;
    end else begin
      return $clog2(depth + 1);
    end
  endfunction

endpackage

// File: rtl/fifo_shift_fwft_if.sv
// Handshake bundle between a producer/consumer and the FIFO.
//   wr_en/wr_data/wr_ready : write side
//   rd_en/rd_val/rd_data   : read side
// master = the agent using the FIFO, slave = the FIFO itself.
interface fifo_shift_fwft_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  rd_en;
  logic                  rd_val;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_en, wr_data, rd_en,
    input  wr_ready, rd_val, rd_data
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output wr_ready, rd_val, rd_data
  );

endinterface

// File: rtl/fifo_shift_fwft_stage.sv
// One storage entry of the shift FIFO.
//   clk       : clock
//   sel       : hold / shift in from the next entry / load write data
//   shift_in  : contents of the next entry towards the tail
//   load_data : write data
//   q         : stored word
// Entries carry no reset; validity is tracked by the occupancy counter.
module fifo_shift_stage
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  stage_sel_e            sel,
  input  logic [DATA_WIDTH-1:0] shift_in,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] q
);

  // Entry register with three-way input mux.
  always_ff @(posedge clk) begin
    case (sel)
      STG_SHIFT: q <= shift_in;
      STG_LOAD:  q <= load_data;
      default:   q <= q;
    endcase
  end

endmodule

// File: rtl/fifo_shift_fwft.sv
// Shift-register FIFO with optional show-ahead read.
//   clk, reset    : clock, synchronous active-high reset
//   flush         : synchronous clear of occupancy
//   bus           : write/read handshake (slave side)
//   count         : occupancy 0..FIFO_DEPTH
//   almost_full   : count >= AF_LEVEL
//   almost_empty  : count <= AE_LEVEL
//   overflow      : pulse the cycle after a rejected write
//   underflow     : pulse the cycle after a rejected read
// queue[0] is the head; pops shift every entry one place towards it.
module fifo_shift_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter bit SHOW_AHEAD = RD_SHOW_AHEAD,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int CNT_W      = cnt_width(FIFO_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  fifo_shift_fwft_if.slave   bus,
  output logic [CNT_W-1:0]   count,
  output logic               almost_full,
  output logic               almost_empty,
  output logic               overflow,
  output logic               underflow
);

  logic                  push;
  logic                  pop;
  stage_sel_e            sel   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] queue [FIFO_DEPTH];

  // Readiness depends on state only, never on the request inputs.
  assign bus.wr_ready = (count != CNT_W'(FIFO_DEPTH));
  assign bus.rd_val   = (count != {CNT_W{1'b0}});

  // Flush discards any transfer requested in the same cycle.
  assign push = bus.wr_en & bus.wr_ready & ~flush;
  assign pop  = bus.rd_en & bus.rd_val & ~flush;

  assign almost_full  = (int'(count) >= AF_LEVEL);
  assign almost_empty = (int'(count) <= AE_LEVEL);

  // Per-entry mux select: on a pop everything shifts and a concurrent
  // write lands one slot lower (count-1) than it would without the pop.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      sel[i] = STG_HOLD;
      if (pop) begin
        if (push && (count == CNT_W'(i + 1))) begin
          sel[i] = STG_LOAD;
        end else begin
          sel[i] = STG_SHIFT;
        end
      end else if (push && (count == CNT_W'(i))) begin
        sel[i] = STG_LOAD;
      end else begin
        sel[i] = STG_HOLD;
      end
    end
  end

  for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_stage
    logic [DATA_WIDTH-1:0] shift_in;
    // The tail has nothing behind it; it keeps its stale word, which is
    // no longer counted as valid after the shift.
    if (g == FIFO_DEPTH - 1) begin : g_tail
      assign shift_in = queue[g];
    end else begin : g_body
      assign shift_in = queue[g+1];
    end

    fifo_shift_stage #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_stage (
      .clk       (clk),
      .sel       (sel[g]),
      .shift_in  (shift_in),
      .load_data (bus.wr_data),
      .q         (queue[g])
    );
  end

  if (SHOW_AHEAD == RD_SHOW_AHEAD) begin : g_show_ahead
    assign bus.rd_data = queue[0];
  end else begin : g_registered
    logic [DATA_WIDTH-1:0] rd_q;

    // Capture the head on a pop; holds through flush.
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_q <= {DATA_WIDTH{1'b0}};
      end else if (pop) begin
        rd_q <= queue[0];
      end else begin
        rd_q <= rd_q;
      end
    end

    assign bus.rd_data = rd_q;
  end

  // Occupancy counter; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {CNT_W{1'b0}};
    end else if (flush) begin
      count <= {CNT_W{1'b0}};
    end else if (push && !pop) begin
      count <= count + CNT_W'(1);
    end else if (pop && !push) begin
      count <= count - CNT_W'(1);
    end else begin
      count <= count;
    end
  end

  // Error pulses, suppressed while flushing.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= bus.wr_en & ~bus.wr_ready & ~flush;
      underflow <= bus.rd_en & ~bus.rd_val & ~flush;
    end
  end

endmodule

// File: tb/tb_fifo_shift_fwft.sv
// Directed bench: dut_a is show-ahead, dut_b is registered-read; both depth 4.
module tb_fifo_shift_fwft;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush_a;
  logic       flush_b;
  logic [2:0] count_a;
  logic [2:0] count_b;
  logic       af_a, ae_a, ovf_a, unf_a;
  logic       af_b, ae_b, ovf_b, unf_b;
  int         total = 0;
  int         bad   = 0;

  fifo_shift_fwft_if #(.DATA_WIDTH(8)) ifa ();
  fifo_shift_fwft_if #(.DATA_WIDTH(8)) ifb ();

  always #5 clk = ~clk;

  fifo_shift_fwft #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .SHOW_AHEAD(1'b1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush_a), .bus(ifa), .count(count_a),
    .almost_full(af_a), .almost_empty(ae_a), .overflow(ovf_a), .underflow(unf_a)
  );

  fifo_shift_fwft #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .SHOW_AHEAD(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush_b), .bus(ifb), .count(count_b),
    .almost_full(af_b), .almost_empty(ae_b), .overflow(ovf_b), .underflow(unf_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++; if (count_a !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count_a); end
    total++; if (ifa.rd_val !== 1'b0) begin bad++; $display("FAIL rst_rd_val got=%b want=0", ifa.rd_val); end
    total++; if (ifa.wr_ready !== 1'b1) begin bad++; $display("FAIL rst_wr_ready got=%b want=1", ifa.wr_ready); end
    total++; if ({af_a, ae_a} !== 2'b01) begin bad++; $display("FAIL rst_flags got af,ae=%b want=01", {af_a, ae_a}); end
    total++; if ({ovf_a, unf_a} !== 2'b00) begin bad++; $display("FAIL rst_err got=%b want=00", {ovf_a, unf_a}); end
    total++; if (ifb.rd_data !== 8'h00) begin bad++; $display("FAIL rst_rd_data_b got=%h want=00", ifb.rd_data); end
    reset = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      ifa.wr_en = 1'b1; ifa.wr_data = vals[k];
      step();
      if (k == 2) begin
        total++; if (af_a !== 1'b1 || count_a !== 3'd3) begin bad++; $display("FAIL af_at3 got af=%b cnt=%0d want af=1 cnt=3", af_a, count_a); end
      end
    end
    ifa.wr_en = 1'b0;
    total++; if (count_a !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", count_a); end
    total++; if (ifa.wr_ready !== 1'b0) begin bad++; $display("FAIL full_wr_ready got=%b want=0", ifa.wr_ready); end
    total++; if ({af_a, ae_a} !== 2'b10) begin bad++; $display("FAIL full_flags got af,ae=%b want=10", {af_a, ae_a}); end
    for (int k = 0; k < 4; k++) begin
      ifa.rd_en = 1'b1;
      total++; if (ifa.rd_data !== vals[k]) begin bad++; $display("FAIL drain_data[%0d] got=%h want=%h", k, ifa.rd_data, vals[k]); end
      step();
    end
    ifa.rd_en = 1'b0;
    total++; if (count_a !== 3'd0 || ae_a !== 1'b1 || ifa.rd_val !== 1'b0) begin bad++; $display("FAIL empty_state got cnt=%0d ae=%b val=%b want 0,1,0", count_a, ae_a, ifa.rd_val); end
  endtask

  task automatic test_overflow();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      ifa.wr_en = 1'b1; ifa.wr_data = vals[k];
      step();
    end
    ifa.rd_en = 1'b1; ifa.wr_data = 8'h55;
    step();
    ifa.wr_en = 1'b0; ifa.rd_en = 1'b0;
    total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b want=1", ovf_a); end
    total++; if (count_a !== 3'd3) begin bad++; $display("FAIL ovf_count got=%0d want=3", count_a); end
    total++; if (ifa.rd_data !== 8'h22) begin bad++; $display("FAIL ovf_head got=%h want=22", ifa.rd_data); end
    step();
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL ovf_one_cycle got=%b want=0", ovf_a); end
    for (int k = 1; k < 4; k++) begin
      ifa.rd_en = 1'b1;
      total++; if (ifa.rd_data !== vals[k]) begin bad++; $display("FAIL ovf_drain[%0d] got=%h want=%h", k, ifa.rd_data, vals[k]); end
      step();
    end
    ifa.rd_en = 1'b0;
    total++; if (count_a !== 3'd0) begin bad++; $display("FAIL ovf_no_store got cnt=%0d want=0", count_a); end
  endtask

  task automatic test_underflow();
    ifa.wr_en = 1'b1; ifa.rd_en = 1'b1; ifa.wr_data = 8'h77;
    step();
    ifa.wr_en = 1'b0; ifa.rd_en = 1'b0;
    total++; if (unf_a !== 1'b1) begin bad++; $display("FAIL unf_pulse got=%b want=1", unf_a); end
    total++; if (count_a !== 3'd1 || ifa.rd_val !== 1'b1) begin bad++; $display("FAIL unf_state got cnt=%0d val=%b want 1,1", count_a, ifa.rd_val); end
    total++; if (ifa.rd_data !== 8'h77) begin bad++; $display("FAIL unf_data got=%h want=77", ifa.rd_data); end
    step();
    total++; if (unf_a !== 1'b0) begin bad++; $display("FAIL unf_one_cycle got=%b want=0", unf_a); end
    ifa.rd_en = 1'b1;
    step();
    ifa.rd_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    ifa.wr_en = 1'b1; ifa.wr_data = 8'hA0; step();
    ifa.wr_data = 8'hA1; step();
    ifa.wr_en = 1'b0;
    total++; if (count_a !== 3'd2 || {af_a, ae_a} !== 2'b00) begin bad++; $display("FAIL b2b_pre got cnt=%0d af,ae=%b want 2,00", count_a, {af_a, ae_a}); end
    ifa.wr_en = 1'b1; ifa.rd_en = 1'b1; ifa.wr_data = 8'hA2;
    total++; if (ifa.rd_data !== 8'hA0) begin bad++; $display("FAIL b2b_head0 got=%h want=a0", ifa.rd_data); end
    step();
    ifa.wr_en = 1'b0;
    total++; if (count_a !== 3'd2 || ifa.rd_data !== 8'hA1) begin bad++; $display("FAIL b2b_mid got cnt=%0d data=%h want 2,a1", count_a, ifa.rd_data); end
    total++; if ({ovf_a, unf_a} !== 2'b00) begin bad++; $display("FAIL b2b_err got=%b want=00", {ovf_a, unf_a}); end
    step();
    total++; if (count_a !== 3'd1 || ifa.rd_data !== 8'hA2 || ae_a !== 1'b1) begin bad++; $display("FAIL b2b_last got cnt=%0d data=%h ae=%b want 1,a2,1", count_a, ifa.rd_data, ae_a); end
    step();
    ifa.rd_en = 1'b0;
  endtask

  task automatic test_registered();
    ifb.wr_en = 1'b1; ifb.wr_data = 8'h10; step();
    ifb.wr_data = 8'h20; step();
    ifb.wr_en = 1'b0;
    total++; if (ifb.rd_data !== 8'h00) begin bad++; $display("FAIL reg_before_pop got=%h want=00", ifb.rd_data); end
    ifb.rd_en = 1'b1; step(); ifb.rd_en = 1'b0;
    total++; if (ifb.rd_data !== 8'h10 || count_b !== 3'd1) begin bad++; $display("FAIL reg_pop1 got data=%h cnt=%0d want 10,1", ifb.rd_data, count_b); end
    step();
    total++; if (ifb.rd_data !== 8'h10) begin bad++; $display("FAIL reg_hold got=%h want=10", ifb.rd_data); end
    ifb.rd_en = 1'b1; step(); ifb.rd_en = 1'b0;
    total++; if (ifb.rd_data !== 8'h20 || count_b !== 3'd0) begin bad++; $display("FAIL reg_pop2 got data=%h cnt=%0d want 20,0", ifb.rd_data, count_b); end
  endtask

  task automatic test_flush();
    ifa.wr_en = 1'b1;
    ifa.wr_data = 8'h31; step();
    ifa.wr_data = 8'h32; step();
    ifa.wr_data = 8'h33; step();
    flush_a = 1'b1; ifa.wr_data = 8'h99;
    step();
    flush_a = 1'b0; ifa.wr_en = 1'b0;
    total++; if (count_a !== 3'd0 || ifa.rd_val !== 1'b0 || ifa.wr_ready !== 1'b1) begin bad++; $display("FAIL flush_state got cnt=%0d val=%b rdy=%b want 0,0,1", count_a, ifa.rd_val, ifa.wr_ready); end
    total++; if ({ovf_a, unf_a} !== 2'b00) begin bad++; $display("FAIL flush_err got=%b want=00", {ovf_a, unf_a}); end
    ifa.wr_en = 1'b1; ifa.wr_data = 8'h01; step(); ifa.wr_en = 1'b0;
    total++; if (ifa.rd_data !== 8'h01 || count_a !== 3'd1) begin bad++; $display("FAIL flush_rewrite got data=%h cnt=%0d want 01,1", ifa.rd_data, count_a); end
    ifa.rd_en = 1'b1; step(); ifa.rd_en = 1'b0;
    // Registered mode: flush with a read pending must keep rd_data and raise no underflow.
    ifb.wr_en = 1'b1; ifb.wr_data = 8'h40; step(); ifb.wr_en = 1'b0;
    flush_b = 1'b1; ifb.rd_en = 1'b1;
    step();
    total++; if (ifb.rd_data !== 8'h20 || count_b !== 3'd0) begin bad++; $display("FAIL flush_b_hold got data=%h cnt=%0d want 20,0", ifb.rd_data, count_b); end
    step();
    flush_b = 1'b0; ifb.rd_en = 1'b0;
    total++; if (unf_b !== 1'b0) begin bad++; $display("FAIL flush_b_unf got=%b want=0", unf_b); end
  endtask

  task automatic test_reset_midstream();
    ifa.wr_en = 1'b1; ifa.wr_data = 8'h5A; step();
    ifa.wr_data = 8'h5B; reset = 1'b1;
    step();
    reset = 1'b0; ifa.wr_en = 1'b0;
    total++; if (count_a !== 3'd0 || ifa.rd_val !== 1'b0) begin bad++; $display("FAIL midrst_a got cnt=%0d val=%b want 0,0", count_a, ifa.rd_val); end
    total++; if (ifb.rd_data !== 8'h00) begin bad++; $display("FAIL midrst_b_data got=%h want=00", ifb.rd_data); end
  endtask

  initial begin
    reset = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
    ifa.wr_en = 1'b0; ifa.rd_en = 1'b0; ifa.wr_data = 8'h00;
    ifb.wr_en = 1'b0; ifb.rd_en = 1'b0; ifb.wr_data = 8'h00;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_registered();
    test_flush();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
